// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder.
// Handshake: the slave accepts start (with a/b) at any edge where busy=0. done pulses for one cycle when sum/carry_out update.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             dbg_state;

    modport master (
        output start, a, b,
        input  busy, done, sum, carry_out, dbg_state
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry_out, dbg_state
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock, through a full adder built from two half_adder cells.
// The result and carry-out are registered and held between completions.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [0:0]    S_IDLE = 1'b0;
    localparam logic [0:0]    S_ADD  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_cout;
    logic             r_done;

    logic             w_s0;
    logic             w_c0;
    logic             w_s;
    logic             w_c1;
    logic             w_cn;
    logic [WIDTH-1:0] w_acc_next;

    half_adder u_ha0 (.i_a(r_sa[0]), .i_b(r_sb[0]), .o_sum(w_s0), .o_carry(w_c0));
    half_adder u_ha1 (.i_a(w_s0),    .i_b(r_c),     .o_sum(w_s),  .o_carry(w_c1));

    assign w_cn = w_c0 | w_c1;
    // New bit enters at the MSB; after WIDTH shifts the first bit has reached bit 0.
    assign w_acc_next = WIDTH'({w_s, r_acc} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_c     <= 1'b0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_acc <= w_acc_next;
                    r_c   <= w_cn;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_cn;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == S_ADD);
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cout;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 1-bit instance against an arithmetic reference (a+b).
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) b8 ();
    serial_adder_if #(.WIDTH(1)) b1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc;
    logic [7:0] m_sum;
    logic       m_cout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation and let the next edge accept it.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        b8.start = 1'b1;
        b8.a     = a;
        b8.b     = b;
        tick();
        b8.start = 1'b0;
        b8.a     = 8'($urandom_range(0, 255));
        b8.b     = 8'($urandom_range(0, 255));
        cyc      = 0;
        chk("accept_busy", 32'(b8.busy), 32'd1);
        chk("accept_done", 32'(b8.done), 32'd0);
        chk("accept_sum_hold", 32'(b8.sum), 32'(m_sum));
    endtask

    // Wait (bounded) for completion of an operation on a,b and check it against a+b.
    task automatic wait_done(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b};
        while (cyc < 40) begin
            tick();
            cyc++;
            if (b8.done) break;
            chk("mid_busy", 32'(b8.busy), 32'd1);
            chk("mid_sum_hold", 32'(b8.sum), 32'(m_sum));
            chk("mid_cout_hold", 32'(b8.carry_out), 32'(m_cout));
        end
        chk("latency", 32'(cyc), 32'd8);
        chk("done_sum", 32'(b8.sum), 32'(exp[7:0]));
        chk("done_cout", 32'(b8.carry_out), 32'(exp[8]));
        chk("done_busy", 32'(b8.busy), 32'd0);
        m_sum  = exp[7:0];
        m_cout = exp[8];
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [1:0] w1_exp [4];
        int         seen;

        w1_exp   = '{2'b00, 2'b10, 2'b10, 2'b01};
        b8.start = 1'b0; b8.a = '0; b8.b = '0;
        b1.start = 1'b0; b1.a = '0; b1.b = '0;
        m_sum    = 8'h00;
        m_cout   = 1'b0;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(b8.busy), 32'd0);
        chk("rst_done", 32'(b8.done), 32'd0);
        chk("rst_sum", 32'(b8.sum), 32'd0);
        chk("rst_cout", 32'(b8.carry_out), 32'd0);
        chk("rst_busy1", 32'(b1.busy), 32'd0);
        chk("rst_sum1", 32'(b1.sum), 32'd0);
        rst = 1'b0;
        tick();

        // Basic and carry-ripple cases
        start_op(8'h01, 8'h01); wait_done(8'h01, 8'h01);
        tick();
        chk("done_single_cycle", 32'(b8.done), 32'd0);
        start_op(8'hFF, 8'h01); wait_done(8'hFF, 8'h01);
        tick();
        start_op(8'hA5, 8'h5A); wait_done(8'hA5, 8'h5A);
        tick();
        start_op(8'hFF, 8'hFF); wait_done(8'hFF, 8'hFF);
        tick();

        // Start while busy is ignored
        start_op(8'h10, 8'h20);
        tick(); cyc++;
        tick(); cyc++;
        b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF;
        tick(); cyc++;
        b8.start = 1'b0;
        wait_done(8'h10, 8'h20);
        tick();
        chk("ignored_no_relaunch", 32'(b8.busy), 32'd0);
        chk("ignored_done_low", 32'(b8.done), 32'd0);

        // Back-to-back: start presented in the done cycle
        start_op(8'h01, 8'h02); wait_done(8'h01, 8'h02);
        start_op(8'h80, 8'h80); wait_done(8'h80, 8'h80);
        tick();

        // Reset in the middle of an operation
        start_op(8'h0F, 8'h01);
        tick(); cyc++;
        tick(); cyc++;
        tick(); cyc++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(b8.busy), 32'd0);
        chk("midrst_done", 32'(b8.done), 32'd0);
        chk("midrst_sum", 32'(b8.sum), 32'd0);
        chk("midrst_cout", 32'(b8.carry_out), 32'd0);
        m_sum  = 8'h00;
        m_cout = 1'b0;
        seen   = 0;
        repeat (12) begin
            tick();
            if (b8.done) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        start_op(8'h0F, 8'h01); wait_done(8'h0F, 8'h01);

        // Random operands, occasionally back-to-back
        repeat (24) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            start_op(ra, rb);
            wait_done(ra, rb);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // WIDTH=1 instance: half_adder truth table, done one cycle after accept
        tick();
        for (int i = 0; i < 4; i++) begin
            b1.start = 1'b1;
            b1.a     = 1'(i >> 1);
            b1.b     = 1'(i);
            tick();
            b1.start = 1'b0;
            chk("w1_accept_busy", 32'(b1.busy), 32'd1);
            chk("w1_accept_done", 32'(b1.done), 32'd0);
            tick();
            chk("w1_done", 32'(b1.done), 32'd1);
            chk("w1_busy", 32'(b1.busy), 32'd0);
            chk("w1_sum", 32'(b1.sum), 32'(w1_exp[i][1]));
            chk("w1_cout", 32'(b1.carry_out), 32'(w1_exp[i][0]));
            tick();
            chk("w1_done_clear", 32'(b1.done), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
